// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-ASCII serializer and related display blocks.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        EMIT = 2'd2,
        TERM = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int DIGITS_DEFAULT = 10;

    function automatic int bcd_width(input int digits);
        return 4 * digits;
    endfunction

    localparam int BCD_W = bcd_width(DIGITS_DEFAULT);

endpackage

// File: rtl/bcd_digit_ascii.sv
// Combinational BCD nibble to ASCII digit; nibbles above 9 map to '?' and flag invalid.
module bcd_digit_ascii
    import bcd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_char,
    output logic       o_invalid
);

    always_comb begin
        o_invalid = (i_nibble > 4'd9);
        o_char    = o_invalid ? ASCII_QMARK : (ASCII_ZERO + {4'h0, i_nibble});
    end

endmodule

// File: rtl/bcd_ascii_serializer.sv
// Streams a packed BCD word as ASCII digits, MSD first, with leading-zero suppression.
// Define BCD_ASCII_NEWLINE_EN to append a line feed after the final digit.
module bcd_ascii_serializer
    import bcd_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  bcd_valid,
    output logic                  bcd_ready,
    output logic [7:0]            char,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  last,
    output logic                  busy,
    output logic                  err
);

    localparam int SHIFT_W = bcd_width(DIGITS);
    localparam int CNT_W   = $clog2(DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

    state_t             r_state;
    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_char;
    logic               r_char_valid;
    logic               r_last;
    logic               r_err;
    logic               r_bcd_ready;

    logic [3:0] w_top_nib;
    logic [3:0] w_next_nib;
    logic [3:0] w_map_nib;
    logic [7:0] w_map_char;
    logic       w_map_inv;
    logic       w_accept;
    logic       w_last_first;
    logic       w_last_next;

    assign w_top_nib  = r_shift[SHIFT_W-1 -: 4];
    assign w_next_nib = r_shift[SHIFT_W-5 -: 4];
    // In EMIT the register still holds the digit being shown, so look one nibble ahead.
    assign w_map_nib  = (r_state == EMIT) ? w_next_nib : w_top_nib;
    assign w_accept   = r_char_valid && char_ready;

`ifdef BCD_ASCII_NEWLINE_EN
    assign w_last_first = 1'b0;
    assign w_last_next  = 1'b0;
`else
    assign w_last_first = (r_count == CNT_ONE);
    assign w_last_next  = (r_count == CNT_TWO);
`endif

    bcd_digit_ascii u_digit (
        .i_nibble  (w_map_nib),
        .o_char    (w_map_char),
        .o_invalid (w_map_inv)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_count      <= '0;
            r_char       <= 8'h00;
            r_char_valid <= 1'b0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
            r_bcd_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bcd_ready <= 1'b1;
                    if (r_bcd_ready && bcd_valid) begin
                        r_shift     <= bcd;
                        r_count     <= CNT_FULL;
                        r_bcd_ready <= 1'b0;
                        r_state     <= SKIP;
                    end
                end
                SKIP: begin
                    if ((w_top_nib == 4'h0) && (r_count > CNT_ONE)) begin
                        r_shift <= {r_shift[SHIFT_W-5:0], 4'h0};
                        r_count <= r_count - CNT_ONE;
                    end else begin
                        r_char       <= w_map_char;
                        r_char_valid <= 1'b1;
                        r_last       <= w_last_first;
                        r_err        <= r_err | w_map_inv;
                        r_state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_accept) begin
                        r_shift <= {r_shift[SHIFT_W-5:0], 4'h0};
                        r_count <= r_count - CNT_ONE;
                        if (r_count == CNT_ONE) begin
`ifdef BCD_ASCII_NEWLINE_EN
                            r_char  <= ASCII_LF;
                            r_last  <= 1'b1;
                            r_state <= TERM;
`else
                            r_char       <= 8'h00;
                            r_char_valid <= 1'b0;
                            r_last       <= 1'b0;
                            r_bcd_ready  <= 1'b1;
                            r_state      <= IDLE;
`endif
                        end else begin
                            r_char <= w_map_char;
                            r_last <= w_last_next;
                            r_err  <= r_err | w_map_inv;
                        end
                    end
                end
`ifdef BCD_ASCII_NEWLINE_EN
                TERM: begin
                    if (w_accept) begin
                        r_char       <= 8'h00;
                        r_char_valid <= 1'b0;
                        r_last       <= 1'b0;
                        r_bcd_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bcd_ready  = r_bcd_ready;
    assign char       = r_char;
    assign char_valid = r_char_valid;
    assign last       = r_last;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Scoreboard bench for bcd_ascii_serializer: directed cases plus randomized words.
module tb_bcd_ascii_serializer;
    import bcd_pkg::*;

    localparam int DIGITS = DIGITS_DEFAULT;
    localparam int W      = 4 * DIGITS;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] bcd = '0;
    logic         bcd_valid = 1'b0;
    logic         bcd_ready;
    logic [7:0]   char;
    logic         char_valid;
    logic         char_ready = 1'b1;
    logic         last;
    logic         busy;
    logic         err;

    typedef struct packed {
        logic [7:0] c;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic exp_err = 1'b0;
    int   rdy_mode = 0;

    bcd_ascii_serializer #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .char       (char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .last       (last),
        .busy       (busy),
        .err        (err)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every digit from the first nonzero (or the units digit) onward is printed.
    task automatic push_word(input logic [W-1:0] w, output int nz, output int nchars);
        logic       started;
        logic [3:0] nib;
        exp_t       e;
        started = 1'b0;
        nz      = 0;
        nchars  = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = w[4*i +: 4];
            if (!started && nib == 4'h0 && i > 0) begin
                nz++;
            end else begin
                started = 1'b1;
                if (nib <= 4'd9) begin
                    e.c = 8'd48 + {4'h0, nib};
                end else begin
                    e.c     = 8'd63;
                    exp_err = 1'b1;
                end
`ifdef BCD_ASCII_NEWLINE_EN
                e.l = 1'b0;
`else
                e.l = (i == 0);
`endif
                q.push_back(e);
                nchars++;
            end
        end
`ifdef BCD_ASCII_NEWLINE_EN
        e.c = 8'd10;
        e.l = 1'b1;
        q.push_back(e);
        nchars++;
`endif
    endtask

    task automatic send_word(input logic [W-1:0] w, output int nchars);
        int nz;
        int n;
        for (int i = 0; i < 100 && !bcd_ready; i++) begin
            @(posedge clock);
            #1;
        end
        chk("bcd_ready_before_send", bcd_ready, 1);
        bcd       = w;
        bcd_valid = 1'b1;
        push_word(w, nz, nchars);
        @(posedge clock);
        #1;
        bcd_valid = 1'b0;
        n = 0;
        while (!char_valid && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("first_char_latency", n, 1 + nz);
    endtask

    task automatic wait_done(output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (char_valid) cyc++;
            if (char_valid && char_ready && last) begin
                ok = 1'b1;
                break;
            end
        end
        chk("word_completes", ok, 1);
        @(posedge clock);
        #1;
        chk("bcd_ready_after_last", bcd_ready, 1);
        chk("busy_after_last", busy, 0);
    endtask

    task automatic run_word(input logic [W-1:0] w, input bit check_tp);
        int nchars;
        int cyc;
        send_word(w, nchars);
        wait_done(cyc);
        if (check_tp) chk("chars_back_to_back", cyc, nchars);
    endtask

    function automatic logic [W-1:0] gen_word();
        logic [W-1:0] w;
        logic [3:0]   nib;
        int           len;
        w   = '0;
        len = $urandom_range(0, DIGITS);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 15) == 0) nib = 4'($urandom_range(10, 15));
            else                            nib = 4'($urandom_range(0, 9));
            w[4*i +: 4] = nib;
        end
        return w;
    endfunction

    initial forever begin
        @(posedge clock);
        #1;
        if (rdy_mode == 1) char_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every accepted char and checks stability under stall.
    initial begin
        bit         held;
        logic [7:0] hc;
        logic       hl;
        exp_t       e;
        held = 1'b0;
        hc   = 8'h00;
        hl   = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_char_stable", char, hc);
                    chk("stall_last_stable", last, hl);
                    chk("stall_valid_stable", char_valid, 1);
                end
                if (char_valid && char_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char: got %0h expected none", char);
                    end else begin
                        e = q.pop_front();
                        chk("char", char, e.c);
                        chk("last", last, e.l);
                    end
                end
                held = char_valid && !char_ready;
                hc   = char;
                hl   = last;
            end
        end
    end

    initial begin
        int nchars;
        int cyc;

        #3;
        chk("rst_bcd_ready", bcd_ready, 0);
        chk("rst_char", char, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        #9;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("bcd_ready_after_reset", bcd_ready, 1);

        run_word(40'h0000000002, 1);
        run_word(40'h0000000000, 1);
        chk("err_after_zero", err, 0);
        run_word(40'h4294967295, 1);

        // Backpressure: stall three cycles while '2' is presented.
        send_word(40'h0000000123, nchars);
        chk("bp_first_char", char, 8'h31);
        @(posedge clock);
        #1;
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_held_char", char, 8'h32);
            @(posedge clock);
            #1;
        end
        char_ready = 1'b1;
        wait_done(cyc);
        chk("bp_err", err, 0);

        run_word(40'h00000000A5, 1);
        chk("err_after_invalid", err, 1);
        run_word(40'h0000000007, 1);
        chk("err_sticky", err, 1);

        // Reset in the middle of emitting a full-width word.
        send_word(40'h4294967295, nchars);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_char_valid", char_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_bcd_ready", bcd_ready, 0);
        chk("midrst_last", last, 0);
        chk("midrst_err", err, 0);
        q.delete();
        exp_err = 1'b0;
        #10;
        reset = 1'b0;
        run_word(40'h4294967295, 1);

        rdy_mode = 1;
        for (int k = 0; k < 30; k++) begin
            run_word(gen_word(), 0);
            chk("rand_err", err, exp_err);
        end
        rdy_mode   = 0;
        char_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
